// File: rtl/ball_physics.sv
// Two-axis tilt-maze ball motion: velocity update on the motion tick, then
// position update and wall handling on the following cycle.
`timescale 1ns/1ps
module ball_physics #(
  parameter int POS_W    = 8,
  parameter int SUB_W    = 4,
  parameter int VEL_W    = 5,
  parameter int VMAX     = 15,
  parameter int TICK_M   = 1350000,
  parameter int START_X  = 128,
  parameter int START_Y  = 188,
  parameter int FRICTION = 1,
  parameter int BOUNCE   = 0
) (
  input  logic               clk108MHz,
  input  logic               resetPressed,
  input  logic               up,
  input  logic               down,
  input  logic               left,
  input  logic               right,
  input  logic               wallAboveball,
  input  logic               wallBelowball,
  input  logic               wallLeftOfball,
  input  logic               wallRightOfball,
  output logic [POS_W-1:0]   ballColumn,
  output logic [POS_W-1:0]   ballRow,
  output logic [VEL_W-1:0]   xVel,
  output logic [VEL_W-1:0]   yVel,
  output logic               bump,
  output logic               moving
);

  localparam int ACC_W = POS_W + SUB_W;
  localparam int SUM_W = ACC_W + 2;
  localparam int CNT_W = (TICK_M > 1) ? $clog2(TICK_M) : 1;
  localparam logic [CNT_W-1:0]        LAST_COUNT = CNT_W'(TICK_M - 1);
  localparam logic signed [VEL_W-1:0] VMAX_S     = VEL_W'(VMAX);
  localparam logic [ACC_W-1:0]        X_START    = ACC_W'(START_X * (2 ** SUB_W));
  localparam logic [ACC_W-1:0]        Y_START    = ACC_W'(START_Y * (2 ** SUB_W));
  localparam logic signed [SUM_W-1:0] ACC_MAX    = {2'b00, {ACC_W{1'b1}}};

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic [VEL_W-1:0] vel;
    logic             hit;
  } axisT;

  logic [CNT_W-1:0] tickCount;
  logic             tick;
  logic             tickD;
  logic [ACC_W-1:0] xAcc;
  logic [ACC_W-1:0] yAcc;
  logic [VEL_W-1:0] xVelNext;
  logic [VEL_W-1:0] yVelNext;
  axisT             xMove;
  axisT             yMove;

  // Tilt integration: saturating step toward the held direction, else friction.
  function automatic logic [VEL_W-1:0] stage1Vel(input logic [VEL_W-1:0] vel,
                                                 input logic plus, input logic minus);
    logic signed [VEL_W-1:0] v;
    logic [VEL_W-1:0]        r;
    v = $signed(vel);
    r = vel;
    if (plus && !minus) begin
      if (v < VMAX_S) r = vel + VEL_W'(1);
    end else if (minus && !plus) begin
      if (v > -VMAX_S) r = vel - VEL_W'(1);
    end else if (FRICTION != 0) begin
      if (v > 0)      r = vel - VEL_W'(1);
      else if (v < 0) r = vel + VEL_W'(1);
    end
    return r;
  endfunction

  // Wall in the direction of motion stops or reflects; the arena edge clamps.
  function automatic axisT stage2(input logic [ACC_W-1:0] acc, input logic [VEL_W-1:0] vel,
                                  input logic wallPlus, input logic wallMinus);
    logic signed [VEL_W-1:0] v;
    logic signed [SUM_W-1:0] sum;
    axisT                    r;
    v     = $signed(vel);
    sum   = $signed({2'b00, acc}) + SUM_W'(v);
    r.acc = acc;
    r.vel = vel;
    r.hit = 1'b0;
    if ((v > 0 && wallPlus) || (v < 0 && wallMinus)) begin
      r.vel = (BOUNCE != 0) ? -vel : '0;
      r.hit = 1'b1;
    end else if (sum < 0) begin
      r.acc = '0;
      r.vel = '0;
    end else if (sum > ACC_MAX) begin
      r.acc = '1;
      r.vel = '0;
    end else begin
      r.acc = sum[ACC_W-1:0];
    end
    return r;
  endfunction

  always_comb begin
    xVelNext = stage1Vel(xVel, right, left);
    yVelNext = stage1Vel(yVel, down, up);
    xMove    = stage2(xAcc, xVel, wallRightOfball, wallLeftOfball);
    yMove    = stage2(yAcc, yVel, wallBelowball, wallAboveball);
  end

  always_ff @(posedge clk108MHz or posedge resetPressed) begin
    if (resetPressed) begin
      tickCount <= '0;
      tick      <= 1'b0;
      tickD     <= 1'b0;
      xVel      <= '0;
      yVel      <= '0;
      xAcc      <= X_START;
      yAcc      <= Y_START;
      bump      <= 1'b0;
    end else begin
      tickCount <= (tickCount == LAST_COUNT) ? '0 : tickCount + CNT_W'(1);
      tick      <= (tickCount == LAST_COUNT);
      tickD     <= tick;
      bump      <= 1'b0;
      if (tick) begin
        xVel <= xVelNext;
        yVel <= yVelNext;
      end else if (tickD) begin
        xAcc <= xMove.acc;
        xVel <= xMove.vel;
        yAcc <= yMove.acc;
        yVel <= yMove.vel;
        bump <= xMove.hit | yMove.hit;
      end
    end
  end

  assign ballColumn = xAcc[ACC_W-1:SUB_W];
  assign ballRow    = yAcc[ACC_W-1:SUB_W];
  assign moving     = (|xVel) | (|yVel);

endmodule

// File: tb/tb_ball_physics.sv
// Bench for ball_physics: three instances (default, no friction, bounce with
// START_Y = 2) driven tick by tick from vector tables and short loops.
`timescale 1ns/1ps
module tb_ball_physics;

  localparam int NDUT = 3;

  // in = {up, down, left, right, wallAbove, wallBelow, wallLeft, wallRight}
  typedef struct packed {
    logic [7:0]  in;
    logic [4:0]  xMid;
    logic [4:0]  xFin;
    logic [11:0] xAcc;
    logic [4:0]  yMid;
    logic [4:0]  yFin;
    logic [11:0] yAcc;
    logic        bump;
  } vecT;

  localparam logic [7:0] I_NONE  = 8'h00;
  localparam logic [7:0] I_UP    = 8'h80;
  localparam logic [7:0] I_DOWN  = 8'h40;
  localparam logic [7:0] I_LEFT  = 8'h20;
  localparam logic [7:0] I_RIGHT = 8'h10;
  localparam logic [7:0] W_LEFT  = 8'h02;
  localparam logic [7:0] W_RIGHT = 8'h01;

  logic        clk108MHz = 1'b0;
  logic        resetPressed = 1'b0;
  logic [7:0]  inA     [NDUT];
  logic [7:0]  colA    [NDUT];
  logic [7:0]  rowA    [NDUT];
  logic [4:0]  xVelA   [NDUT];
  logic [4:0]  yVelA   [NDUT];
  logic        bumpA   [NDUT];
  logic        movingA [NDUT];
  logic [11:0] xAccA   [NDUT];
  logic [11:0] yAccA   [NDUT];
  logic        tickA   [NDUT];

  int compared = 0;
  int mismatched = 0;
  int cycle = 0;
  int lastTick = -1;

  vecT exp_q[$];
  logic [4:0]  curXVel, curYVel;
  logic [11:0] curXAcc, curYAcc;

  always #5 clk108MHz = ~clk108MHz;
  always @(posedge clk108MHz) cycle <= cycle + 1;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g
    ball_physics #(
      .TICK_M(4), .SUB_W(4),
      .FRICTION((gi == 1) ? 0 : 1),
      .BOUNCE((gi == 2) ? 1 : 0),
      .START_Y((gi == 2) ? 2 : 188)
    ) u (
      .clk108MHz(clk108MHz), .resetPressed(resetPressed),
      .up(inA[gi][7]), .down(inA[gi][6]), .left(inA[gi][5]), .right(inA[gi][4]),
      .wallAboveball(inA[gi][3]), .wallBelowball(inA[gi][2]),
      .wallLeftOfball(inA[gi][1]), .wallRightOfball(inA[gi][0]),
      .ballColumn(colA[gi]), .ballRow(rowA[gi]),
      .xVel(xVelA[gi]), .yVel(yVelA[gi]),
      .bump(bumpA[gi]), .moving(movingA[gi])
    );
    assign xAccA[gi] = u.xAcc;
    assign yAccA[gi] = u.yAcc;
    assign tickA[gi] = u.tick;
  end

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vecT mkv(input logic [7:0] in, input int xm, input int xf, input int xa,
                              input int ym, input int yf, input int ya, input int b);
    vecT v;
    v.in   = in;
    v.xMid = 5'(xm);
    v.xFin = 5'(xf);
    v.xAcc = 12'(xa);
    v.yMid = 5'(ym);
    v.yFin = 5'(yf);
    v.yAcc = 12'(ya);
    v.bump = (b != 0);
    return v;
  endfunction

  // Async reset asserted between clock edges; outputs must settle with no edge.
  task automatic doReset();
    @(posedge clk108MHz);
    #2;
    resetPressed = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check("rstColumn", colA[d], 128);
      check("rstRow", rowA[d], (d == 2) ? 2 : 188);
      check("rstXVel", $signed(xVelA[d]), 0);
      check("rstYVel", $signed(yVelA[d]), 0);
      check("rstBump", bumpA[d], 0);
      check("rstMoving", movingA[d], 0);
      check("rstTick", tickA[d], 0);
    end
    for (int d = 0; d < NDUT; d++) inA[d] = I_NONE;
    @(negedge clk108MHz);
    @(negedge clk108MHz);
    resetPressed = 1'b0;
    lastTick = -1;
  endtask

  task automatic startState(input int d);
    curXVel = '0;
    curYVel = '0;
    curXAcc = 12'd2048;
    curYAcc = (d == 2) ? 12'd32 : 12'd3008;
  endtask

  // One motion tick on instance d: drive, wait for the strobe, check latencies.
  task automatic step(input int d, input vecT e);
    vecT h;
    int  waited;
    for (int i = 0; i < NDUT; i++) inA[i] = (i == d) ? e.in : I_NONE;
    exp_q.push_back(e);
    waited = 0;
    do begin
      @(negedge clk108MHz);
      waited++;
    end while (!tickA[d] && waited < 20);
    if (!tickA[d]) begin
      compared++;
      mismatched++;
      $display("FAIL tickTimeout: got no tick in %0d cycles expected one within 4", waited);
      void'(exp_q.pop_front());
      return;
    end
    if (lastTick >= 0) check("tickSpacing", cycle - lastTick, 4);
    lastTick = cycle;
    check("holdXVel", $signed(xVelA[d]), $signed(curXVel));
    check("holdYVel", $signed(yVelA[d]), $signed(curYVel));
    @(negedge clk108MHz);
    check("xVel+1", $signed(xVelA[d]), $signed(e.xMid));
    check("yVel+1", $signed(yVelA[d]), $signed(e.yMid));
    check("xAcc+1", xAccA[d], curXAcc);
    check("yAcc+1", yAccA[d], curYAcc);
    check("bump+1", bumpA[d], 0);
    @(negedge clk108MHz);
    h = exp_q.pop_front();
    check("xVel+2", $signed(xVelA[d]), $signed(h.xFin));
    check("yVel+2", $signed(yVelA[d]), $signed(h.yFin));
    check("xAcc+2", xAccA[d], h.xAcc);
    check("yAcc+2", yAccA[d], h.yAcc);
    check("ballColumn", colA[d], h.xAcc >> 4);
    check("ballRow", rowA[d], h.yAcc >> 4);
    check("bump+2", bumpA[d], h.bump);
    check("moving", movingA[d], (h.xFin != 0) || (h.yFin != 0));
    @(negedge clk108MHz);
    check("bump+3", bumpA[d], 0);
    check("xVel+3", $signed(xVelA[d]), $signed(h.xFin));
    curXVel = h.xFin;
    curYVel = h.yFin;
    curXAcc = h.xAcc;
    curYAcc = h.yAcc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    vecT p1 [7];
    vecT p2 [7];
    vecT p3 [21];
    int  v, a;

    for (int d = 0; d < NDUT; d++) inA[d] = I_NONE;

    // Default instance: ramp, friction, saturation, wall stop, y friction.
    p1[0] = mkv(I_RIGHT, 1, 1, 2049, 0, 0, 3008, 0);
    p1[1] = mkv(I_RIGHT, 2, 2, 2051, 0, 0, 3008, 0);
    p1[2] = mkv(I_RIGHT, 3, 3, 2054, 0, 0, 3008, 0);
    p1[3] = mkv(I_NONE,  2, 2, 2056, 0, 0, 3008, 0);
    p1[4] = mkv(I_NONE,  1, 1, 2057, 0, 0, 3008, 0);
    p1[5] = mkv(I_NONE,  0, 0, 2057, 0, 0, 3008, 0);
    p1[6] = mkv(I_NONE,  0, 0, 2057, 0, 0, 3008, 0);

    // No friction: velocity holds on release and with both directions held.
    p2[0] = mkv(I_RIGHT,          1, 1, 2049, 0, 0, 3008, 0);
    p2[1] = mkv(I_RIGHT,          2, 2, 2051, 0, 0, 3008, 0);
    p2[2] = mkv(I_RIGHT,          3, 3, 2054, 0, 0, 3008, 0);
    p2[3] = mkv(I_NONE,           3, 3, 2057, 0, 0, 3008, 0);
    p2[4] = mkv(I_NONE,           3, 3, 2060, 0, 0, 3008, 0);
    p2[5] = mkv(I_NONE,           3, 3, 2063, 0, 0, 3008, 0);
    p2[6] = mkv(I_LEFT | I_RIGHT, 3, 3, 2066, 0, 0, 3008, 0);

    // Bounce instance (START_Y = 2): reflect off right wall, then top clamp.
    p3[0]  = mkv(I_RIGHT,           1,  1, 2049, 0, 0, 32, 0);
    p3[1]  = mkv(I_RIGHT,           2,  2, 2051, 0, 0, 32, 0);
    p3[2]  = mkv(I_RIGHT,           3,  3, 2054, 0, 0, 32, 0);
    p3[3]  = mkv(I_RIGHT,           4,  4, 2058, 0, 0, 32, 0);
    p3[4]  = mkv(I_RIGHT | W_RIGHT, 5, -5, 2058, 0, 0, 32, 1);
    p3[5]  = mkv(I_NONE,           -4, -4, 2054, 0, 0, 32, 0);
    p3[6]  = mkv(I_NONE,           -3, -3, 2051, 0, 0, 32, 0);
    p3[7]  = mkv(I_NONE,           -2, -2, 2049, 0, 0, 32, 0);
    p3[8]  = mkv(I_NONE,           -1, -1, 2048, 0, 0, 32, 0);
    p3[9]  = mkv(I_NONE,            0,  0, 2048, 0, 0, 32, 0);
    p3[10] = mkv(I_UP,          0, 0, 2048, -1, -1, 31, 0);
    p3[11] = mkv(I_UP | I_DOWN, 0, 0, 2048,  0,  0, 31, 0);
    p3[12] = mkv(I_UP,          0, 0, 2048, -1, -1, 30, 0);
    p3[13] = mkv(I_UP,          0, 0, 2048, -2, -2, 28, 0);
    p3[14] = mkv(I_UP,          0, 0, 2048, -3, -3, 25, 0);
    p3[15] = mkv(I_UP,          0, 0, 2048, -4, -4, 21, 0);
    p3[16] = mkv(I_UP,          0, 0, 2048, -5, -5, 16, 0);
    p3[17] = mkv(I_UP,          0, 0, 2048, -6, -6, 10, 0);
    p3[18] = mkv(I_UP,          0, 0, 2048, -7, -7,  3, 0);
    p3[19] = mkv(I_UP,          0, 0, 2048, -8,  0,  0, 0);
    p3[20] = mkv(I_UP,          0, 0, 2048, -1,  0,  0, 0);

    doReset();
    startState(0);
    for (int i = 0; i < 7; i++) step(0, p1[i]);

    v = 0;
    a = 2057;
    for (int i = 0; i < 19; i++) begin
      v = (v < 15) ? v + 1 : 15;
      a = a + v;
      step(0, mkv(I_RIGHT, v, v, a, 0, 0, 3008, 0));
    end
    while (v > 6) begin
      v = v - 1;
      a = a + v;
      step(0, mkv(I_NONE, v, v, a, 0, 0, 3008, 0));
    end
    step(0, mkv(W_RIGHT, 5, 0, a, 0, 0, 3008, 1));
    step(0, mkv(I_UP,          0, 0, a, -1, -1, 3007, 0));
    step(0, mkv(I_UP,          0, 0, a, -2, -2, 3005, 0));
    step(0, mkv(I_UP | I_DOWN, 0, 0, a, -1, -1, 3004, 0));
    step(0, mkv(I_UP | I_DOWN, 0, 0, a,  0,  0, 3004, 0));
    step(0, mkv(I_RIGHT | W_LEFT, 1, 1, a + 1, 0, 0, 3004, 0));

    doReset();
    startState(1);
    for (int i = 0; i < 7; i++) step(1, p2[i]);

    doReset();
    startState(2);
    for (int i = 0; i < 21; i++) step(2, p3[i]);

    check("queueEmpty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ball_physics.md
Name: ball_physics

Overview:
- Parametrised two-axis ball motion engine for the tilt-maze game. Runs on a shared motion tick.
- Integrates button "tilt" inputs into signed, saturating velocity with optional friction decay.
- Integrates velocity into a fixed-point position with sub-pixel resolution, handling wall contact by stopping or bouncing.
- Feeds ballColumn/ballRow to the maze renderer and collision lookup.

Parameters:
- POS_W, 8, integer pixel-position width per axis.
- SUB_W, 4, fractional position bits (velocity unit = 1/2^SUB_W pixel per tick).
- VEL_W, 5, signed velocity width per axis (two's complement).
- VMAX, 15, velocity magnitude limit; must satisfy VMAX <= 2^(VEL_W-1)-1.
- TICK_M, 1350000, clock cycles per motion tick.
- START_X, 128, reset column (integer pixels).
- START_Y, 188, reset row (integer pixels).
- FRICTION, 1, 1 = velocity decays toward 0 by 1 per tick when no input on that axis.
- BOUNCE, 0, 0 = velocity zeroed on wall contact; 1 = velocity negated.

Ports:
- clk108MHz, in, 1, system clock.
- resetPressed, in, 1, asynchronous active-high reset.
- up, down, left, right, in, 1 each, tilt requests (level).
- wallAboveball, wallBelowball, wallLeftOfball, wallRightOfball, in, 1 each, wall adjacent to ball on that side (level, from collision lookup).
- ballColumn, out, POS_W, integer x position.
- ballRow, out, POS_W, integer y position.
- xVel, yVel, out, VEL_W signed, current velocities.
- bump, out, 1, one-cycle pulse on any wall contact that changed velocity.
- moving, out, 1, high when xVel != 0 or yVel != 0.

Behaviour:

Reset (async, any time including mid-tick):
- Tick counter = 0; tick and stage-2 strobes = 0.
- xVel = yVel = 0; bump = 0.
- Position accumulators = {START_X,0^SUB_W} and {START_Y,0^SUB_W}, so ballColumn = START_X and ballRow = START_Y.

Tick generation:
- Counter 0..TICK_M-1, wraps.
- Registered strobe tick = 1 for exactly one cycle when the counter = TICK_M-1.
- A single counter serves both axes, so the axes stay in lockstep.

Stage 1, on the edge where tick = 1 (per axis; x uses right = +, left = -; y uses down = +, up = -):
- Only + held: vel = min(vel+1, VMAX).
- Only - held: vel = max(vel-1, -VMAX).
- Both or neither held: if FRICTION = 1, vel moves 1 toward 0 (0 stays 0); if FRICTION = 0, vel holds.
- Saturation is exact; the velocity never wraps.

Stage 2, on the edge after stage 1 (strobe tick_d), using the updated vel:
- Positive vel with a wall on the + side (wallRightOfball / wallBelowball), or negative vel with a wall on the - side (wallLeftOfball / wallAboveball):
  - Position unchanged.
  - vel becomes 0 (BOUNCE = 0) or -vel (BOUNCE = 1).
  - bump = 1 for this one cycle.
- Otherwise: acc = acc + sign_extend(vel).
  - Result clamps to [0, 2^(POS_W+SUB_W)-1].
  - Never wraps.
  - At a clamp, vel is zeroed; bump is not asserted.
- A wall on the side opposite to motion is ignored.
- vel = 0 means no update and no bump.

Latency:
- Velocity is visible 1 cycle after tick.
- Position and bump are visible 2 cycles after tick.
- Between strobes, all outputs hold.

Pin behaviour:
- Inputs are sampled only on strobe cycles; presses shorter than a tick may be missed, by design.
- Outputs are registered.
- moving is combinational from the vel registers.

Test Plan (bench uses TICK_M = 4, SUB_W = 4, defaults otherwise):
- Reset mid-tick → ballColumn = 128, ballRow = 188, xVel = yVel = 0, bump = 0 immediately, with no clock edge required.
- Hold right, no walls, 3 ticks → xVel = 1, 2, 3; accumulator x = 2048+1, +3, +6 (ballColumn still 128). After 16 more ticks, xVel saturates at 15 and never reaches 16.
- Release all with xVel = 3, FRICTION = 1 → xVel = 2, 1, 0, 0 on successive ticks; moving falls with the 0. With FRICTION = 0, xVel holds at 3.
- xVel = 5, wallRightOfball = 1 at stage 2:
  - BOUNCE = 0 → position unchanged, xVel = 0, bump high for 1 cycle.
  - BOUNCE = 1 → xVel = -5, bump high for 1 cycle.
  - wallLeftOfball = 1 alone → normal move, no bump.
- Hold up and down together with yVel = -2, FRICTION = 1 → yVel = -1, then 0. Hold up near the top (ballRow = 0, frac = 3), vel = -8 → accumulator clamps to 0, yVel = 0, bump = 0.
- Check tick spacing = TICK_M cycles; velocity changes exactly 1 cycle and position exactly 2 cycles after each tick.
